// File: rtl/pipelined_sat_addsub.sv
// Pipelined two's-complement adder/subtractor with optional saturation and NZCV-style flags.
// Latency STAGES cycles, throughput 1 op/cycle; CLA groups of GROUP bits split evenly over the stages.
// Backpressure: every stage advances together when the output is empty or drained (in_ready = adv).
module pipelined_sat_addsub #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,      // synchronous, active low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,        // 1: a-b, 0: a+b
    input  logic             sat,        // 1: clamp on signed overflow
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             cout,
    output logic             zero,
    output logic             neg
);

    localparam int N   = WIDTH / GROUP;   // number of CLA groups
    localparam int GPS = N / STAGES;      // groups handled per stage
    localparam int SW  = GPS * GROUP;     // bits handled per stage
    localparam int M   = WIDTH - 1;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // One carry-lookahead group: every internal carry is a flat sum of
    // generate/propagate products rather than a ripple chain.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             cin);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             prop;
        g = x & y;
        p = x ^ y;
        for (int i = 0; i <= GROUP; i++) begin
            c[i] = 1'b0;
            prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i] = c[i] | (prop & cin);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    for (genvar st = 0; st < STAGES; st++) begin : stg
        // AW: operand bits not yet summed when entering this stage.
        localparam int AW = WIDTH - st * SW;

        logic                vld_i;
        logic                sub_i;
        logic                sat_i;
        logic                c_i;
        logic [AW-1:0]       a_i;
        logic [AW-1:0]       b_i;
        logic [SW-1:0]       b_eff;
        logic [SW-1:0]       s_cur;
        logic                c_out;
        logic [(st+1)*SW-1:0] sum_acc;   // all sum bits known after this stage

        if (st == 0) begin : head
            assign vld_i   = in_valid;
            assign sub_i   = sub;
            assign sat_i   = sat;
            assign c_i     = sub;          // carry-in 1 completes the two's complement of b
            assign a_i     = a;
            assign b_i     = b;
            assign sum_acc = s_cur;
        end else begin : link
            assign vld_i   = stg[st-1].pr.vld_q;
            assign sub_i   = stg[st-1].pr.sub_q;
            assign sat_i   = stg[st-1].pr.sat_q;
            assign c_i     = stg[st-1].pr.c_q;
            assign a_i     = stg[st-1].pr.a_q;
            assign b_i     = stg[st-1].pr.b_q;
            assign sum_acc = {s_cur, stg[st-1].pr.sum_q};
        end

        assign b_eff = b_i[SW-1:0] ^ {SW{sub_i}};

        always_comb begin
            logic           c;
            logic [GROUP:0] r;
            c     = c_i;
            r     = '0;
            s_cur = '0;
            for (int k = 0; k < GPS; k++) begin
                r = cla_group(a_i[k*GROUP +: GROUP], b_eff[k*GROUP +: GROUP], c);
                s_cur[k*GROUP +: GROUP] = r[GROUP-1:0];
                c = r[GROUP];
            end
            c_out = c;
        end

        if (st < STAGES - 1) begin : pr
            logic                 vld_q;
            logic                 sub_q;
            logic                 sat_q;
            logic                 c_q;
            logic [AW-SW-1:0]     a_q;
            logic [AW-SW-1:0]     b_q;
            logic [(st+1)*SW-1:0] sum_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    sub_q <= 1'b0;
                    sat_q <= 1'b0;
                    c_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                end else if (adv) begin
                    vld_q <= vld_i;
                    sub_q <= sub_i;
                    sat_q <= sat_i;
                    c_q   <= c_out;
                    a_q   <= a_i[AW-1:SW];
                    b_q   <= b_i[AW-1:SW];
                    sum_q <= sum_acc;
                end
            end
        end else begin : po
            logic             am;
            logic             bm;
            logic             sm;
            logic             ovf_n;
            logic [WIDTH-1:0] res_n;

            // The MSBs of a and b are in this stage's slice (raw, before inversion).
            always_comb begin
                am    = a_i[SW-1];
                bm    = b_i[SW-1];
                sm    = sum_acc[M];
                ovf_n = sub_i ? ((am ^ bm) & (sm ^ am)) : (~(am ^ bm) & (sm ^ am));
                res_n = sum_acc;
                // On overflow the true result has a's sign, so a[M] picks the rail.
                if (sat_i && ovf_n) begin
                    res_n = am ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                    ovf       <= 1'b0;
                    cout      <= 1'b0;
                    zero      <= 1'b0;
                    neg       <= 1'b0;
                end else if (adv) begin
                    out_valid <= vld_i;
                    result    <= res_n;
                    ovf       <= ovf_n;
                    cout      <= c_out;
                    zero      <= (res_n == '0);
                    neg       <= res_n[M];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_sat_addsub.sv
// Testbench for pipelined_sat_addsub: three instances (16b/2 stages, 16b/1 stage, 32b/4 stages).
// Directed vector table on the 2-stage instance, a per-instance scoreboard against an arithmetic model,
// plus hand sequences for stall, mid-flight reset and random backpressure.
module tb_pipelined_sat_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, sub, sat, out_ready;
    logic [31:0] a, b;

    logic        in_ready0, out_valid0, ovf0, cout0, zero0, neg0;
    logic [15:0] result0;
    logic        in_ready1, out_valid1, ovf1, cout1, zero1, neg1;
    logic [15:0] result1;
    logic        in_ready2, out_valid2, ovf2, cout2, zero2, neg2;
    logic [31:0] result2;

    pipelined_sat_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .sat(sat),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
        .ovf(ovf0), .cout(cout0), .zero(zero0), .neg(neg0));

    pipelined_sat_addsub #(.WIDTH(16), .GROUP(4), .STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .sat(sat),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .ovf(ovf1), .cout(cout1), .zero(zero1), .neg(neg1));

    pipelined_sat_addsub #(.WIDTH(32), .GROUP(4), .STAGES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .ovf(ovf2), .cout(cout2), .zero(zero2), .neg(neg2));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {ovf, cout, zero, neg}
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] res;
        logic [3:0]  flg;   // {ovf, cout, zero, neg}
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, then wrap or clamp.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic sb, input logic st, input int w);
        exp_t            e;
        longint unsigned mask, ua, ub, full, raw;
        longint          sa, sbv, tr, mx, mn, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'h0, av} & mask;
        ub   = {32'h0, bv} & mask;
        full = sb ? ua + (~ub & mask) + 64'd1 : ua + ub;
        raw  = full & mask;
        mx   = longint'((64'd1 << (w - 1)) - 64'd1);
        mn   = -mx - 1;
        sa   = (ua > 64'(mx)) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sbv  = (ub > 64'(mx)) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        tr   = sb ? sa - sbv : sa + sbv;
        if (st && tr > mx)      r = mx;
        else if (st && tr < mn) r = mn;
        else                    r = longint'(raw);
        e.res    = 32'(r & longint'(mask));
        e.flg[3] = (tr > mx) || (tr < mn);
        e.flg[2] = ((full >> w) & 64'd1) != 0;
        e.flg[1] = (e.res == 32'h0);
        e.flg[0] = ((e.res >> (w - 1)) & 32'h1) != 0;
        return e;
    endfunction

    task automatic sb_cmp(input string nm, input logic [31:0] res, input logic [3:0] flg,
                          input exp_t e);
        chk({nm, "_res"}, res, e.res);
        chk({nm, "_flg"}, {28'h0, flg}, {28'h0, e.flg});
    endtask

    // One clock: settle, score the handshakes that the coming edge will perform, then step.
    task automatic cycle();
        exp_t e;
        #1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                chk("sb0_has_entry", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    sb_cmp("sb0", {16'h0, result0}, {ovf0, cout0, zero0, neg0}, e);
                end
            end
            if (out_valid1 && out_ready) begin
                chk("sb1_has_entry", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    sb_cmp("sb1", {16'h0, result1}, {ovf1, cout1, zero1, neg1}, e);
                end
            end
            if (out_valid2 && out_ready) begin
                chk("sb2_has_entry", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    sb_cmp("sb2", result2, {ovf2, cout2, zero2, neg2}, e);
                end
            end
            if (in_valid && in_ready0) q0.push_back(model(a, b, sub, sat, 16));
            if (in_valid && in_ready1) q1.push_back(model(a, b, sub, sat, 16));
            if (in_valid && in_ready2) q2.push_back(model(a, b, sub, sat, 32));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        vt[10];
    logic [31:0] ra[8], rb[8];
    logic        rsub[8], rsat[8];
    logic [15:0] snap_res;
    logic [3:0]  snap_flg;
    int          lat, lat0, lat1, lat2, idx, seen;
    logic        acc;

    initial begin
        vt[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b1000};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1001};
        vt[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101};
        vt[3] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b0110};
        vt[4] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000};
        vt[5] = '{16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1000, 4'b0000};
        vt[6] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0110};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1101};
        vt[8] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 4'b1000};
        vt[9] = '{16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 4'b0100};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        #1;
        chk("rst_out_valid0", 32'(out_valid0), 0);
        chk("rst_result0", 32'(result0), 0);
        chk("rst_flags0", {28'h0, ovf0, cout0, zero0, neg0}, 0);
        chk("rst_in_ready0", 32'(in_ready0), 1);
        chk("rst_out_valid12", {30'h0, out_valid1, out_valid2}, 0);
        rst_n = 1'b1;
        cycle();

        // Latency of each instance for a single isolated op.
        in_valid = 1'b1; a = 32'd1; b = 32'd2;
        cycle();
        in_valid = 1'b0; lat0 = 0; lat1 = 0; lat2 = 0;
        for (int n = 1; n <= 8; n++) begin
            if (out_valid0 && lat0 == 0) lat0 = n;
            if (out_valid1 && lat1 == 0) lat1 = n;
            if (out_valid2 && lat2 == 0) lat2 = n;
            cycle();
        end
        chk("latency_s2", lat0, 2);
        chk("latency_s1", lat1, 1);
        chk("latency_s4", lat2, 4);

        // Directed vectors, one op in flight at a time.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = {16'h0, vt[i].a}; b = {16'h0, vt[i].b};
            sub = vt[i].sub; sat = vt[i].sat;
            cycle();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid0 && lat < 8) begin
                cycle();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_result", i), 32'(result0), 32'(vt[i].res));
            chk($sformatf("vec%0d_flags", i), {28'h0, ovf0, cout0, zero0, neg0}, 32'(vt[i].flg));
        end
        repeat (6) cycle();

        // Back-to-back stream of 8 random ops with a 3-cycle output stall.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom; rb[i] = $urandom;
            rsub[i] = 1'($urandom_range(0, 1)); rsat[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            out_ready = !(c >= 4 && c < 7);
            in_valid = 1'b1; a = ra[idx]; b = rb[idx]; sub = rsub[idx]; sat = rsat[idx];
            #1;
            if (c == 4) begin
                chk("stall_out_valid", 32'(out_valid0), 1);
                snap_res = result0;
                snap_flg = {ovf0, cout0, zero0, neg0};
            end
            if (c >= 4 && c < 7) chk($sformatf("stall_in_ready_c%0d", c), 32'(in_ready0), 0);
            if (c >= 5 && c <= 7) begin
                chk($sformatf("stall_hold_res_c%0d", c), 32'(result0), 32'(snap_res));
                chk($sformatf("stall_hold_flg_c%0d", c), {28'h0, ovf0, cout0, zero0, neg0},
                    32'(snap_flg));
            end
            acc = in_ready0;
            cycle();
            if (acc) idx++;
        end
        chk("stream_all_accepted", idx, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) cycle();
        chk("stream_q0_drained", q0.size(), 0);

        // Reset with two ops in flight: both must vanish.
        in_valid = 1'b1; a = 32'h0000_1111; b = 32'h0000_2222; sub = 1'b0; sat = 1'b0;
        cycle();
        a = 32'h0000_3333; b = 32'h0000_0001; sub = 1'b1;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(out_valid0), 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid0), 0);
        chk("midrst_result", 32'(result0), 0);
        chk("midrst_flags", {28'h0, ovf0, cout0, zero0, neg0}, 0);
        chk("midrst_in_ready", 32'(in_ready0), 1);
        out_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            if (out_valid0 || out_valid1 || out_valid2) seen = 1;
            cycle();
        end
        chk("midrst_no_ghost", seen, 0);

        // Random traffic with random backpressure on all three instances.
        for (int n = 0; n < 60; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && (q0.size() + q1.size() + q2.size()) != 0; n++) cycle();
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
